// File: rtl/spi_regbank_periph.sv
// SPI (mode 0) register-bank peripheral.
// Frames (MSB first: rw, addr, data) are sampled in the clk domain. Valid
// writes update one DATA_W-bit control register and pulse its write strobe.
// Reads return the register on cipo. Rejected frames bump a saturating
// error counter.
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   copi, sclk, ncs       SPI pins, asynchronous to clk
//   cipo, cipo_oe         read data out and its pad enable (high while selected)
//   regs_flat             register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_strobe             one-clk pulse on bit i when reg i is written
//   err_count             saturating count of rejected frames
module spi_regbank_periph #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       copi,
    input  logic                       sclk,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        wr_strobe,
    output logic [7:0]                 err_count
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int OCNT_W  = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  FRAME_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  ADDR_CNT  = CNT_W'(ADDR_W);
    localparam logic [OCNT_W-1:0] DATA_CNT  = OCNT_W'(DATA_W);
    localparam logic [ADDR_W:0]   NREGS_A   = (ADDR_W + 1)'(NUM_REGS);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] copi_sync, sclk_sync, ncs_sync;
    logic                   sclk_d, ncs_d;
    logic                   copi_s, sclk_s, ncs_s;
    logic                   sclk_rise, sclk_fall, ncs_fall, ncs_rise;

    state_t                 state_q, state_d;
    logic                   do_start, do_shift, do_overrun, do_out_shift, do_eval;

    logic [FRAME_W-1:0]     shreg;
    logic [FRAME_W-1:0]     shift_next;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   overrun;
    logic [DATA_W-1:0]      out_sh;
    logic [OCNT_W-1:0]      out_cnt;
    logic                   cipo_q;
    logic [DATA_W-1:0]      regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_strobe_q;
    logic [7:0]             err_q;

    logic                   rw_bit;
    logic [ADDR_W-1:0]      addr_f;
    logic [DATA_W-1:0]      data_f;
    logic                   frame_valid;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_word;

    // Input synchronisers plus one delay stage for edge decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copi_sync <= '0;
            sclk_sync <= '0;
            ncs_sync  <= '1;
            sclk_d    <= 1'b0;
            ncs_d     <= 1'b1;
        end else begin
            copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ncs_d     <= ncs_sync[SYNC_STAGES-1];
        end
    end

    assign copi_s    = copi_sync[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ncs_fall  = ~ncs_s & ncs_d;
    assign ncs_rise  = ncs_s & ~ncs_d;

    // Frame field decode from the captured shift register.
    assign rw_bit      = shreg[FRAME_W-1];
    assign addr_f      = shreg[DATA_W +: ADDR_W];
    assign data_f      = shreg[DATA_W-1:0];
    assign frame_valid = (bit_cnt == FRAME_CNT) && !overrun && ({1'b0, addr_f} < NREGS_A);

    // After the shift that completes rw+addr, those fields sit in the low bits.
    assign shift_next  = {shreg[FRAME_W-2:0], copi_s};
    assign rd_addr     = shift_next[ADDR_W-1:0];

    always_comb begin
        rd_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_word = regs_q[i];
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ncs_fall) state_d = SHIFT;
            SHIFT:   if (ncs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: control decode. ncs edges take priority, so an sclk edge in the
    // same clk as either ncs edge is dropped.
    always_comb begin
        do_start     = 1'b0;
        do_shift     = 1'b0;
        do_overrun   = 1'b0;
        do_out_shift = 1'b0;
        do_eval      = 1'b0;
        case (state_q)
            IDLE: do_start = ncs_fall;
            SHIFT: begin
                if (ncs_rise) begin
                    do_eval = 1'b1;
                end else if (sclk_rise && !ncs_s) begin
                    if (bit_cnt == FRAME_CNT) do_overrun = 1'b1;
                    else                      do_shift   = 1'b1;
                end else if (sclk_fall && !ncs_s) begin
                    do_out_shift = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            overrun     <= 1'b0;
            out_sh      <= '0;
            out_cnt     <= '0;
            cipo_q      <= 1'b0;
            wr_strobe_q <= '0;
            err_q       <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_strobe_q <= '0;
            if (do_start) begin
                shreg   <= '0;
                bit_cnt <= '0;
                overrun <= 1'b0;
                out_cnt <= '0;
                cipo_q  <= 1'b0;
            end
            if (do_shift) begin
                shreg   <= shift_next;
                bit_cnt <= bit_cnt + CNT_W'(1);
                // Only read frames drive data on cipo; writes keep it at 0.
                if (bit_cnt == ADDR_CNT && !shift_next[ADDR_W]) begin
                    out_sh  <= ({1'b0, rd_addr} < NREGS_A) ? rd_word : '0;
                    out_cnt <= DATA_CNT;
                end
            end
            if (do_overrun) overrun <= 1'b1;
            if (do_out_shift) begin
                if (out_cnt != '0) begin
                    cipo_q  <= out_sh[DATA_W-1];
                    out_sh  <= out_sh << 1;
                    out_cnt <= out_cnt - OCNT_W'(1);
                end else begin
                    cipo_q  <= 1'b0;
                end
            end
            if (do_eval) begin
                cipo_q  <= 1'b0;
                out_cnt <= '0;
                if (frame_valid) begin
                    if (rw_bit) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (addr_f == ADDR_W'(i)) begin
                                regs_q[i]      <= data_f;
                                wr_strobe_q[i] <= 1'b1;
                            end
                        end
                    end
                end else if (err_q != 8'hFF) begin
                    err_q <= err_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
    end

    assign cipo      = cipo_q;
    assign cipo_oe   = ~ncs_s;
    assign wr_strobe = wr_strobe_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_spi_regbank_periph.sv
module tb_spi_regbank_periph;
    localparam int HP = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   copi_p, sclk_p, ncs_p;
    logic         cipo0, oe0, cipo1, oe1;
    logic [39:0]  rf0;
    logic [4:0]   ws0;
    logic [7:0]   ec0;
    logic [127:0] rf1;
    logic [7:0]   ws1;
    logic [7:0]   ec1;

    spi_regbank_periph #(.NUM_REGS(5), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)) u0 (
        .clk(clk), .rst_n(rst_n), .copi(copi_p[0]), .sclk(sclk_p[0]), .ncs(ncs_p[0]),
        .cipo(cipo0), .cipo_oe(oe0), .regs_flat(rf0), .wr_strobe(ws0), .err_count(ec0));

    spi_regbank_periph #(.NUM_REGS(8), .DATA_W(16), .ADDR_W(3), .SYNC_STAGES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .copi(copi_p[1]), .sclk(sclk_p[1]), .ncs(ncs_p[1]),
        .cipo(cipo1), .cipo_oe(oe1), .regs_flat(rf1), .wr_strobe(ws1), .err_count(ec1));

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  m0 [5];
    logic [15:0] m1 [8];

    typedef struct {int inst; logic [7:0] strobe; logic [127:0] regs;} wr_t;
    typedef struct {int inst; logic [15:0] data;} rd_t;
    wr_t wr_q[$];
    rd_t rd_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] flat0();
        logic [127:0] f = '0;
        for (int i = 0; i < 5; i++) f[i*8 +: 8] = m0[i];
        return f;
    endfunction

    function automatic logic [127:0] flat1();
        logic [127:0] f = '0;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = m1[i];
        return f;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_low(input int inst);
        @(negedge clk);
        ncs_p[inst] = 1'b0;
        wait_clks(HP);
    endtask

    task automatic send_bits(input int inst, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            copi_p[inst] = v[i];
            wait_clks(HP);
            sclk_p[inst] = 1'b1;
            wait_clks(HP);
            sclk_p[inst] = 1'b0;
        end
    endtask

    task automatic cs_high(input int inst);
        wait_clks(HP);
        ncs_p[inst] = 1'b1;
        wait_clks(HP + 4);
    endtask

    task automatic frame(input int inst, input logic [31:0] v, input int n);
        cs_low(inst);
        send_bits(inst, v, n);
        cs_high(inst);
    endtask

    task automatic write0(input int addr, input logic [7:0] data);
        wr_t w;
        m0[addr] = data;
        w.inst = 0; w.strobe = 8'(1 << addr); w.regs = flat0();
        wr_q.push_back(w);
        frame(0, {16'h0, 1'b1, 7'(addr), data}, 16);
    endtask

    task automatic read0(input int addr, input logic [7:0] exp);
        rd_t r;
        r.inst = 0; r.data = {8'h0, exp};
        rd_q.push_back(r);
        frame(0, {16'h0, 1'b0, 7'(addr), 8'h00}, 16);
    endtask

    // Monitor: pops expected writes on every strobe and expected read words
    // at the end of every complete read frame.
    function automatic int fw(input int k); return (k == 0) ? 16 : 20; endfunction
    function automatic int aw(input int k); return (k == 0) ? 7 : 3; endfunction

    initial begin : monitor
        logic [1:0]  sclk_prev, ncs_prev, rwb;
        int          bc [2];
        logic [15:0] cap [2];
        wr_t         w;
        rd_t         r;
        logic        cbit;
        sclk_prev = '0; ncs_prev = '1; rwb = '0;
        bc[0] = 0; bc[1] = 0; cap[0] = '0; cap[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (ws0 != '0 || ws1 != '0) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_strobe", {ws1, 3'b0, ws0}, '0);
                end else begin
                    w = wr_q.pop_front();
                    if (w.inst == 0) begin
                        check("strobe0", {120'h0, 3'b0, ws0}, {120'h0, w.strobe});
                        check("regs0_on_strobe", {88'h0, rf0}, w.regs);
                        check("strobe1_idle", {120'h0, ws1}, '0);
                    end else begin
                        check("strobe1", {120'h0, ws1}, {120'h0, w.strobe});
                        check("regs1_on_strobe", rf1, w.regs);
                        check("strobe0_idle", {123'h0, ws0}, '0);
                    end
                end
            end
            for (int k = 0; k < 2; k++) begin
                cbit = (k == 0) ? cipo0 : cipo1;
                if (ncs_prev[k] && !ncs_p[k]) begin
                    bc[k] = 0; cap[k] = '0;
                end
                if (!ncs_p[k] && sclk_p[k] && !sclk_prev[k]) begin
                    bc[k]++;
                    if (bc[k] == 1) rwb[k] = copi_p[k];
                    if (bc[k] > 1 + aw(k) && bc[k] <= fw(k)) cap[k] = {cap[k][14:0], cbit};
                end
                if (!ncs_prev[k] && ncs_p[k] && !rwb[k] && bc[k] == fw(k)) begin
                    if (rd_q.size() == 0) begin
                        check("unexpected_read", 128'(k), 128'(99));
                    end else begin
                        r = rd_q.pop_front();
                        check("read_inst", 128'(k), 128'(r.inst));
                        check("read_data", {112'h0, cap[k]}, {112'h0, r.data});
                    end
                end
            end
            sclk_prev = sclk_p;
            ncs_prev  = ncs_p;
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        rd_t r;
        wr_t w;
        copi_p = '0; sclk_p = '0; ncs_p = '1;
        for (int i = 0; i < 5; i++) m0[i] = '0;
        for (int i = 0; i < 8; i++) m1[i] = '0;
        wait_clks(4);
        check("rst_regs0", {88'h0, rf0}, '0);
        check("rst_misc0", {118'h0, ws0, ec0, cipo0, oe0}, '0);
        check("rst_misc1", {110'h0, ws1, ec1, cipo1, oe1}, '0);
        rst_n = 1'b1;
        wait_clks(4);

        // Write reg0 = 0xA5
        write0(0, 8'hA5);
        check("err_after_write", {120'h0, ec0}, 128'd0);
        check("reg0", {88'h0, rf0}, flat0());

        // Write reg4 = 0x7F, read it back
        write0(4, 8'h7F);
        read0(4, 8'h7F);
        check("regs_after_read", {88'h0, rf0}, flat0());
        check("err_after_read", {120'h0, ec0}, 128'd0);

        // Out-of-range write and read
        frame(0, {16'h0, 1'b1, 7'd5, 8'hFF}, 16);
        check("err_oor_write", {120'h0, ec0}, 128'd1);
        check("regs_oor_write", {88'h0, rf0}, flat0());
        read0(9, 8'h00);
        check("err_oor_read", {120'h0, ec0}, 128'd2);

        // Short (15-bit) and long (17-bit) frames to reg1
        frame(0, {17'h0, 15'h40AA}, 15);
        frame(0, {15'h0, 16'h8155, 1'b0}, 17);
        check("err_short_long", {120'h0, ec0}, 128'd4);
        check("regs_short_long", {88'h0, rf0}, flat0());

        // Saturation: empty frames are always rejected
        for (int i = 0; i < 256; i++) frame(0, 32'h0, 0);
        check("err_saturate", {120'h0, ec0}, 128'd255);

        // Reset in the middle of a write to reg2
        cs_low(0);
        send_bits(0, 32'h823C >> 7, 9);
        check("oe_during_frame", {127'h0, oe0}, 128'd1);
        @(negedge clk);
        rst_n = 1'b0;
        ncs_p[0] = 1'b1;
        sclk_p[0] = 1'b0;
        wait_clks(3);
        for (int i = 0; i < 5; i++) m0[i] = '0;
        check("midrst_regs0", {88'h0, rf0}, '0);
        check("midrst_misc0", {118'h0, ws0, ec0, cipo0, oe0}, '0);
        rst_n = 1'b1;
        wait_clks(5);
        write0(2, 8'h3C);
        check("reg2_after_reset", {88'h0, rf0}, flat0());
        check("err_after_reset", {120'h0, ec0}, 128'd0);

        // Wide instance: reg7 = 0xBEEF, read back
        m1[7] = 16'hBEEF;
        w.inst = 1; w.strobe = 8'h80; w.regs = flat1();
        wr_q.push_back(w);
        frame(1, 32'h000F_BEEF, 20);
        check("reg7_wide", {112'h0, rf1[127:112]}, {112'h0, 16'hBEEF});
        r.inst = 1; r.data = 16'hBEEF;
        rd_q.push_back(r);
        frame(1, 32'h0007_0000, 20);
        check("err_wide", {120'h0, ec1}, 128'd0);
        check("regs0_untouched", {88'h0, rf0}, flat0());

        wait_clks(4);
        check("wr_q_drained", 128'(wr_q.size()), 128'd0);
        check("rd_q_drained", 128'(rd_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
